// File: rtl/arena_scanner_pkg.sv
// Shared definitions for the arena scanner: FSM encodings, coordinate width, beat layout.
package arena_scanner_pkg;
  localparam int COORD_W = 8;

  localparam logic [1:0] SCAN_IDLE  = 2'd0;
  localparam logic [1:0] SCAN_SCAN  = 2'd1;
  localparam logic [1:0] SCAN_DRAIN = 2'd2;

  typedef struct packed {
    logic data;
    logic eol;
    logic eof;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/scan_skid_buf.sv
// Two-entry register FIFO; the head entry only changes on a pop or when empty,
// so the output stays stable while the consumer stalls.
module scan_skid_buf #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] tail;

  assign valid = count != 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop && valid})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count stays put; the new beat lands behind whatever remains
          if (count == 2'd1) head <= push_data;
          else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/arena_scanner.sv
// Row-major arena scanner streaming one cell per beat with eol/eof tags.
// Optional ARENA_SCANNER_ALIVE_COUNT_EN adds a per-frame count of live cells.
module arena_scanner
  import arena_scanner_pkg::*;
#(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  output logic [COORD_W-1:0] arena_rd_column,
  output logic [COORD_W-1:0] arena_rd_row,
  input  logic               arena_rd_data,
  output logic               pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_eol,
  output logic               pix_eof
`ifdef ARENA_SCANNER_ALIVE_COUNT_EN
  ,
  output logic [15:0]        alive_count,
  output logic               alive_count_valid
`endif
);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(ARENA_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ARENA_HEIGHT - 1);

  logic [1:0] state;
  logic       rd_pend, rd_eol, rd_eof;
  logic [1:0] buf_count, occ;
  logic       issue, pop, at_last_col, at_last_row;
  beat_t      push_beat, head;

  assign ready       = state == SCAN_IDLE;
  assign pop         = pix_valid && pix_ready;
  assign at_last_col = arena_rd_column == LAST_COL;
  assign at_last_row = arena_rd_row == LAST_ROW;

  // A slot must be free for the read issued now, counting the one already in
  // flight and any beat leaving this cycle.
  assign occ   = buf_count + {1'b0, rd_pend};
  assign issue = (state == SCAN_SCAN) && ((occ <= 2'd1) || (occ == 2'd2 && pop));

  assign push_beat = '{data: arena_rd_data, eol: rd_eol, eof: rd_eof};

  scan_skid_buf #(.WIDTH(BEAT_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .valid     (pix_valid),
    .count     (buf_count)
  );

  assign pix_data = head.data;
  assign pix_eol  = head.eol;
  assign pix_eof  = head.eof;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= SCAN_IDLE;
      arena_rd_column <= '0;
      arena_rd_row    <= '0;
      rd_pend         <= 1'b0;
      rd_eol          <= 1'b0;
      rd_eof          <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        rd_eol <= at_last_col;
        rd_eof <= at_last_col && at_last_row;
      end
      case (state)
        SCAN_IDLE: if (start) begin
          state           <= SCAN_SCAN;
          arena_rd_column <= '0;
          arena_rd_row    <= '0;
        end
        SCAN_SCAN: if (issue) begin
          if (at_last_col && at_last_row) state <= SCAN_DRAIN;
          else if (at_last_col) begin
            arena_rd_column <= '0;
            arena_rd_row    <= arena_rd_row + 1'b1;
          end else begin
            arena_rd_column <= arena_rd_column + 1'b1;
          end
        end
        SCAN_DRAIN: if (pop && pix_eof) state <= SCAN_IDLE;
        default: state <= SCAN_IDLE;
      endcase
    end
  end

`ifdef ARENA_SCANNER_ALIVE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_count       <= '0;
      alive_count_valid <= 1'b0;
    end else begin
      alive_count_valid <= pop && pix_eof;
      if (ready && start)        alive_count <= '0;
      else if (pop && pix_data)  alive_count <= alive_count + 16'd1;
    end
  end
`endif
endmodule
